// File: rtl/display_pkg.sv
// Shared types and constants for the display scheduler: arbiter states,
// requester count, digit-slot numbering and a lowest-index priority picker.
package display_pkg;

    localparam int         NUM_REQ     = 3;
    localparam logic [1:0] DIGIT_SIGN  = 2'd0;
    localparam logic [1:0] DIGIT_UNITS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } state_t;

    // One-hot of the lowest set bit; req[0] wins.
    function automatic logic [NUM_REQ-1:0] pick_lowest(input logic [NUM_REQ-1:0] r);
        logic [NUM_REQ-1:0] p;
        p = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r[i]) begin
                p    = '0;
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Refresh divider and digit-slot counter; frame_end marks the last clock of
// the units slot, which is where the arbiter is allowed to switch grants.
module scan_timer
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       scan_tick,
    output logic [1:0] digit_sel,
    output logic       frame_end
);

    localparam int            DW      = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);

    logic [DW-1:0] r_div;
    logic [1:0]    r_digit;
    logic          w_tick;

    assign w_tick = (r_div == DIV_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_digit <= DIGIT_SIGN;
        end else if (w_tick) begin
            r_div   <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

    assign scan_tick = w_tick;
    assign digit_sel = r_digit;
    assign frame_end = w_tick && (r_digit == DIGIT_UNITS);

endmodule

// File: rtl/display_scheduler.sv
// Frame-aligned priority arbiter sharing one 4-digit display among three
// requesters. Optional blinking of urgent grants is built with DISPLAY_BLINK_EN.
module display_scheduler
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int HOLD_FRAMES  = 64,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [7:0]          value0,
    input  logic [7:0]          value1,
    input  logic [7:0]          value2,
    input  logic [NUM_REQ-1:0]  urgent,
    output logic [NUM_REQ-1:0]  grant,
    output logic [7:0]          number_out,
    output logic [1:0]          digit_sel,
    output logic                scan_tick,
    output logic                blank
);

    localparam int            HW        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES - 1);
    localparam int            BW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [HW-1:0]      r_hold_cnt;
    logic               w_frame_end;
    logic [NUM_REQ-1:0] w_pick;
    logic               w_rearb;

    scan_timer #(.REFRESH_DIV(REFRESH_DIV)) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_tick (scan_tick),
        .digit_sel (digit_sel),
        .frame_end (w_frame_end)
    );

    assign w_pick  = pick_lowest(req);
    // OPEN always re-arbitrates; HOLD only once its own request has gone away.
    assign w_rearb = (r_state == ST_OPEN) ||
                     ((r_state == ST_HOLD) && !(|(req & r_grant)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_hold_cnt <= '0;
        end else if (w_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant    <= w_pick;
                        r_hold_cnt <= HOLD_LOAD;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD, ST_OPEN: begin
                    if (w_rearb) begin
                        if (w_pick == '0) begin
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end else if (w_pick != r_grant) begin
                            r_grant    <= w_pick;
                            r_hold_cnt <= HOLD_LOAD;
                            r_state    <= ST_HOLD;
                        end else begin
                            r_state <= ST_OPEN;
                        end
                    end else if (r_hold_cnt == '0) begin
                        r_state <= ST_OPEN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;

    always_comb begin
        number_out = 8'h00;
        case (r_grant)
            3'b001:  number_out = value0;
            3'b010:  number_out = value1;
            3'b100:  number_out = value2;
            default: number_out = 8'h00;
        endcase
    end

`ifdef DISPLAY_BLINK_EN
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_FRAMES - 1);

    logic          r_phase;
    logic [BW-1:0] r_blink_cnt;
    logic          w_urg;
    logic          w_grant_chg;

    assign w_urg       = |(urgent & r_grant);
    assign w_grant_chg = ((r_state == ST_IDLE) && (|req)) ||
                         (w_rearb && (w_pick != r_grant));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (!w_urg || (w_frame_end && w_grant_chg)) begin
            r_phase     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_frame_end) begin
            if (r_blink_cnt == BLINK_LOAD) begin
                r_phase     <= ~r_phase;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign blank = (r_state == ST_IDLE) || r_phase;
`else
    logic w_unused_blink;
    assign w_unused_blink = ^{urgent, BW[0]};
    assign blank          = (r_state == ST_IDLE);
`endif

endmodule
